// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [WAIT_W-1:0] TIMEOUT_DEF = 8'd255;
    localparam logic [REG_W-1:0]  REG_ZERO    = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle: decode/execute/memory status in, stage enables out.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] ex_dst;
    logic             ex_load;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_clr;
    logic             idex_clr;
    logic             memwb_clr;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: drives stage status, receives control.
    modport master (
        output id_rs, id_rt, ex_dst, ex_load, br_taken, mem_req, mem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr, memwb_clr,
        input  mem_err, state, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, ex_dst, ex_load, br_taken, mem_req, mem_ack,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr, memwb_clr,
        output mem_err, state, stall_cnt
    );

endinterface

// File: rtl/hz_loaduse_cmp.sv
// Load-use detector: a load in EX writes a nonzero register the ID instruction reads.
module hz_loaduse_cmp
    import hazard_pkg::*;
(
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_dst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    assign load_use = ex_load && (ex_dst != REG_ZERO) &&
                      ((ex_dst == id_rs) || (ex_dst == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch flush,
// load-use bubble, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter logic [WAIT_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         s,
    hazard_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_q;
    logic              err_q, err_d;
    logic              load_use;

    logic pc_we, ifid_we, idex_we, exmem_we;
    logic ifid_clr, idex_clr, memwb_clr;

    hz_loaduse_cmp u_cmp (
        .ex_load  (bus.ex_load),
        .ex_dst   (bus.ex_dst),
        .id_rs    (bus.id_rs),
        .id_rt    (bus.id_rt),
        .load_use (load_use)
    );

    // State, wait counter, error pulse and stall counter registers.
    always_ff @(posedge clk or posedge s) begin
        if (s) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            if (!pc_we && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Next-state and stage-control decode; reset masks every hazard.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        exmem_we  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        memwb_clr = 1'b0;
        if (!s) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_req && !bus.mem_ack) begin
                        {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                        memwb_clr = 1'b1;
                        state_d   = ST_MEM_WAIT;
                        wcnt_d    = WAIT_W'(1);
                    end else if (bus.br_taken) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                    end else if (load_use) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        idex_clr = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.mem_ack) begin
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                    end else begin
                        {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                        memwb_clr = 1'b1;
                        if (wcnt_q == TIMEOUT) begin
                            err_d   = 1'b1;
                            state_d = ST_ERR;
                        end else begin
                            wcnt_d = wcnt_q + WAIT_W'(1);
                        end
                    end
                end
                ST_ERR: begin
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
                    memwb_clr = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    assign bus.pc_we     = pc_we;
    assign bus.ifid_we   = ifid_we;
    assign bus.idex_we   = idex_we;
    assign bus.exmem_we  = exmem_we;
    assign bus.ifid_clr  = ifid_clr;
    assign bus.idex_clr  = idex_clr;
    assign bus.memwb_clr = memwb_clr;
    assign bus.mem_err   = err_q;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, memory wait, timeout, reset, saturation.
module tb_hazard_ctrl;

    logic clk;
    logic s;
    int   n_chk;
    int   n_fail;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.TIMEOUT(8'd255)) dut (
        .clk (clk),
        .s   (s),
        .bus (bus)
    );

    // Control vector order: pc_we ifid_we idex_we exmem_we ifid_clr idex_clr memwb_clr
    localparam logic [6:0] C_DEF    = 7'b1111000;
    localparam logic [6:0] C_LU     = 7'b0011010;
    localparam logic [6:0] C_BR     = 7'b1111110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we,
                bus.ifid_clr, bus.idex_clr, bus.memwb_clr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic ld, input logic br, input logic req, input logic ack);
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.ex_dst   = dst;
        bus.ex_load  = ld;
        bus.br_taken = br;
        bus.mem_req  = req;
        bus.mem_ack  = ack;
    endtask

    // Inputs change on the falling edge; comb outputs are sampled 1 unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        s = 1'b1;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_ctl_masked", 32'(ctl()), 32'(C_DEF));
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_stall", 32'(bus.stall_cnt), 32'd0);
        check("rst_err", 32'(bus.mem_err), 32'd0);

        // Load-use via rs
        step(); s = 1'b0;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("lu_rs_ctl", 32'(ctl()), 32'(C_LU));
        step(); drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("lu_bubble_ctl", 32'(ctl()), 32'(C_DEF));
        check("lu_stall", 32'(bus.stall_cnt), 32'd1);
        check("lu_state", 32'(bus.state), 32'd0);

        // Load-use via rt
        step(); drive(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("lu_rt_ctl", 32'(ctl()), 32'(C_LU));
        // Load to r0 never stalls
        step(); drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("r0_ctl", 32'(ctl()), 32'(C_DEF));
        check("lu_rt_stall", 32'(bus.stall_cnt), 32'd2);
        // Matching register but not a load
        step(); drive(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("noload_ctl", 32'(ctl()), 32'(C_DEF));
        check("r0_stall", 32'(bus.stall_cnt), 32'd2);
        // Branch beats load-use
        step(); drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); #1;
        check("br_ctl", 32'(ctl()), 32'(C_BR));
        // Request acked in the same cycle: no stall
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        check("req_ack_ctl", 32'(ctl()), 32'(C_DEF));
        check("br_stall", 32'(bus.stall_cnt), 32'd2);

        // Memory wait beats branch/load-use; ack on 4th cycle
        step(); drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("req_state0", 32'(bus.state), 32'd0);
        check("mw1_ctl", 32'(ctl()), 32'(C_FREEZE));
        step(); #1;
        check("mw_state", 32'(bus.state), 32'd1);
        check("mw2_ctl", 32'(ctl()), 32'(C_FREEZE));
        step(); #1;
        check("mw3_ctl", 32'(ctl()), 32'(C_FREEZE));
        step(); drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        check("mw_release_ctl", 32'(ctl()), 32'(C_DEF));
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("mw_back_run", 32'(bus.state), 32'd0);
        check("mw_stall", 32'(bus.stall_cnt), 32'd5);

        // Timeout: 1 RUN freeze cycle + 255 MEM_WAIT cycles, then ERR
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (255) step();
        #1;
        check("to_pre_state", 32'(bus.state), 32'd1);
        check("to_pre_err", 32'(bus.mem_err), 32'd0);
        step(); drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1); #1;
        check("to_state_err", 32'(bus.state), 32'd2);
        check("to_err_pulse", 32'(bus.mem_err), 32'd1);
        check("to_stall", 32'(bus.stall_cnt), 32'd261);
        check("err_ignores_ack", 32'(ctl()), 32'(C_FREEZE));
        step(); #1;
        check("err_pulse_end", 32'(bus.mem_err), 32'd0);
        check("err_held", 32'(bus.state), 32'd2);

        // Asynchronous reset out of ERR
        step(); s = 1'b1; #1;
        check("rst_err_state", 32'(bus.state), 32'd0);
        check("rst_err_stall", 32'(bus.stall_cnt), 32'd0);
        check("rst_err_ctl", 32'(ctl()), 32'(C_DEF));
        step(); s = 1'b0;
        drive(5'd0, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("post_rst_lu", 32'(ctl()), 32'(C_LU));

        // Ack in the timeout cycle wins
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (255) step();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        check("to_ack_ctl", 32'(ctl()), 32'(C_DEF));
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("to_ack_state", 32'(bus.state), 32'd0);
        check("to_ack_noerr", 32'(bus.mem_err), 32'd0);
        check("to_ack_stall", 32'(bus.stall_cnt), 32'd256);

        // Long freeze into ERR drives stall_cnt to saturation
        step(); drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65278) step();
        #1;
        check("sat_pre", 32'(bus.stall_cnt), 32'hFFFE);
        step(); #1;
        check("sat_hit", 32'(bus.stall_cnt), 32'hFFFF);
        repeat (10) step();
        #1;
        check("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        check("sat_state", 32'(bus.state), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
